// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with rename tags for a RoB-based core
//
// Holds 32 architectural registers with a busy bit and a RoB tag for each one.
// An issue renames rd to the RoB entry being allocated. A commit from the RoB
// head writes the value, and it frees the register only if that commit came
// from the newest producer. The two source read ports resolve operands in the
// same cycle from, in order: the register file, the committing result, or the
// RoB response.
//
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   rdy                      clock enable; low holds all state
//   clear                    misprediction flush; drops every pending rename
//   issue_valid/rd/rob_id    rename rd to a newly allocated RoB entry
//   commit_valid/rd/rob_id/value  architectural write from the RoB head
//   rs1, rs2                 source indices of the instruction being issued
//   get_rob_id1/2            producer tags sent to the RoB for lookup
//   get_ready1/2, get_value1/2  same-cycle RoB response for those tags
//   val1/2, dep1/2, tag1/2   resolved operand, pending flag, tag to wait on
module reg_file #(
  parameter int ROB_SIZE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      clear,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  input  logic                      commit_valid,
  input  logic [4:0]                commit_rd,
  input  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  input  logic [31:0]               commit_value,
  input  logic [4:0]                rs1,
  input  logic [4:0]                rs2,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id1,
  output logic [ROB_SIZE_WIDTH-1:0] get_rob_id2,
  input  logic                      get_ready1,
  input  logic                      get_ready2,
  input  logic [31:0]               get_value1,
  input  logic [31:0]               get_value2,
  output logic [31:0]               val1,
  output logic [31:0]               val2,
  output logic                      dep1,
  output logic                      dep2,
  output logic [ROB_SIZE_WIDTH-1:0] tag1,
  output logic [ROB_SIZE_WIDTH-1:0] tag2
);

  logic [31:0]               regs    [32];
  logic [ROB_SIZE_WIDTH-1:0] rob_tag [32];
  logic [31:0]               busy;

  // Entry 0 is written only by reset, so x0 stays zero, never busy, tag 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i]    <= '0;
        rob_tag[i] <= '0;
      end
      busy <= '0;
    end else if (rdy) begin
      if (commit_valid && commit_rd != 5'd0) begin
        regs[commit_rd] <= commit_value;
        // An older producer's commit must not free a register that a
        // younger instruction has since renamed.
        if (rob_tag[commit_rd] == commit_rob_id)
          busy[commit_rd] <= 1'b0;
      end
      // The issue comes after the commit, so a rename in the same cycle
      // overrides the busy clear for the same rd.
      if (clear) begin
        busy <= '0;
      end else if (issue_valid && issue_rd != 5'd0) begin
        busy[issue_rd]    <= 1'b1;
        rob_tag[issue_rd] <= issue_rob_id;
      end
    end
  end

  // The read ports see only the registered state, so an instruction whose rd
  // equals its own source picks up the older producer and not itself.
  logic [4:0]                rs_p    [2];
  logic                      ready_p [2];
  logic [31:0]               value_p [2];
  logic [31:0]               val_p   [2];
  logic                      dep_p   [2];
  logic [ROB_SIZE_WIDTH-1:0] tag_p   [2];
  logic [ROB_SIZE_WIDTH-1:0] get_p   [2];

  assign rs_p[0]    = rs1;
  assign rs_p[1]    = rs2;
  assign ready_p[0] = get_ready1;
  assign ready_p[1] = get_ready2;
  assign value_p[0] = get_value1;
  assign value_p[1] = get_value2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      val_p[p] = '0;
      dep_p[p] = 1'b0;
      tag_p[p] = '0;
      get_p[p] = '0;
      if (rs_p[p] != 5'd0) begin
        get_p[p] = rob_tag[rs_p[p]];
        if (!busy[rs_p[p]]) begin
          val_p[p] = regs[rs_p[p]];
        end else if (commit_valid && commit_rd == rs_p[p] &&
                     commit_rob_id == rob_tag[rs_p[p]]) begin
          val_p[p] = commit_value;
        end else if (ready_p[p]) begin
          val_p[p] = value_p[p];
        end else begin
          dep_p[p] = 1'b1;
          tag_p[p] = rob_tag[rs_p[p]];
        end
      end
    end
  end

  assign val1        = val_p[0];
  assign val2        = val_p[1];
  assign dep1        = dep_p[0];
  assign dep2        = dep_p[1];
  assign tag1        = tag_p[0];
  assign tag2        = tag_p[1];
  assign get_rob_id1 = get_p[0];
  assign get_rob_id2 = get_p[1];

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_rob_id;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [3:0]  commit_rob_id;
  logic [31:0] commit_value;
  logic [4:0]  rs1, rs2;
  logic [3:0]  get_rob_id1, get_rob_id2;
  logic        get_ready1, get_ready2;
  logic [31:0] get_value1, get_value2;
  logic [31:0] val1, val2;
  logic        dep1, dep2;
  logic [3:0]  tag1, tag2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  reg_file #(.ROB_SIZE_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .rs1(rs1), .rs2(rs2),
    .get_rob_id1(get_rob_id1), .get_rob_id2(get_rob_id2),
    .get_ready1(get_ready1), .get_ready2(get_ready2),
    .get_value1(get_value1), .get_value2(get_value2),
    .val1(val1), .val2(val2), .dep1(dep1), .dep2(dep2),
    .tag1(tag1), .tag2(tag2)
  );

  task automatic idle();
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
    rs1 = '0; rs2 = '0;
    get_ready1 = 1'b0; get_ready2 = 1'b0; get_value1 = '0; get_value2 = '0;
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rob_id = 4'd3;
    commit_valid = 1'b1; commit_rd = 5'd6; commit_value = 32'h1111;
    step();
    idle();
    rs1 = 5'd5; rs2 = 5'd6;
    #1;
    checks++; if (dep1 !== 1'b0) begin fails++; $display("FAIL rst_dep1 got=%0h exp=0", dep1); end
    checks++; if (val1 !== 32'h0) begin fails++; $display("FAIL rst_val1 got=%0h exp=0", val1); end
    checks++; if (tag1 !== 4'h0) begin fails++; $display("FAIL rst_tag1 got=%0h exp=0", tag1); end
    checks++; if (get_rob_id1 !== 4'h0) begin fails++; $display("FAIL rst_getid1 got=%0h exp=0", get_rob_id1); end
    checks++; if (val2 !== 32'h0) begin fails++; $display("FAIL rst_val2 got=%0h exp=0", val2); end
  endtask

  task automatic test_rename_commit();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd5; issue_rob_id = 4'd3;
    step();
    idle();
    rs1 = 5'd5;
    #1;
    checks++; if (dep1 !== 1'b1) begin fails++; $display("FAIL rn_dep1 got=%0h exp=1", dep1); end
    checks++; if (tag1 !== 4'd3) begin fails++; $display("FAIL rn_tag1 got=%0h exp=3", tag1); end
    checks++; if (get_rob_id1 !== 4'd3) begin fails++; $display("FAIL rn_getid1 got=%0h exp=3", get_rob_id1); end
    checks++; if (val1 !== 32'h0) begin fails++; $display("FAIL rn_val1 got=%0h exp=0", val1); end
    commit_valid = 1'b1; commit_rd = 5'd5; commit_rob_id = 4'd3; commit_value = 32'hDEADBEEF;
    #1;
    checks++; if (val1 !== 32'hDEADBEEF) begin fails++; $display("FAIL byp_val1 got=%0h exp=deadbeef", val1); end
    checks++; if (dep1 !== 1'b0) begin fails++; $display("FAIL byp_dep1 got=%0h exp=0", dep1); end
    checks++; if (tag1 !== 4'd0) begin fails++; $display("FAIL byp_tag1 got=%0h exp=0", tag1); end
    step();
    idle();
    rs1 = 5'd5;
    #1;
    checks++; if (val1 !== 32'hDEADBEEF) begin fails++; $display("FAIL cm_val1 got=%0h exp=deadbeef", val1); end
    checks++; if (dep1 !== 1'b0) begin fails++; $display("FAIL cm_dep1 got=%0h exp=0", dep1); end
    checks++; if (get_rob_id1 !== 4'd3) begin fails++; $display("FAIL cm_getid1 got=%0h exp=3", get_rob_id1); end
  endtask

  task automatic test_stale_commit();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd7; issue_rob_id = 4'd1;
    step();
    issue_rob_id = 4'd2;
    step();
    idle();
    commit_valid = 1'b1; commit_rd = 5'd7; commit_rob_id = 4'd1; commit_value = 32'd9;
    step();
    idle();
    rs2 = 5'd7;
    #1;
    checks++; if (dep2 !== 1'b1) begin fails++; $display("FAIL stale_dep2 got=%0h exp=1", dep2); end
    checks++; if (tag2 !== 4'd2) begin fails++; $display("FAIL stale_tag2 got=%0h exp=2", tag2); end
    get_ready2 = 1'b1; get_value2 = 32'h77;
    #1;
    checks++; if (val2 !== 32'h77) begin fails++; $display("FAIL rob_val2 got=%0h exp=77", val2); end
    checks++; if (dep2 !== 1'b0) begin fails++; $display("FAIL rob_dep2 got=%0h exp=0", dep2); end
    checks++; if (tag2 !== 4'd0) begin fails++; $display("FAIL rob_tag2 got=%0h exp=0", tag2); end
    idle();
    clear = 1'b1;
    step();
    idle();
    rs2 = 5'd7;
    #1;
    checks++; if (val2 !== 32'd9) begin fails++; $display("FAIL stale_reg7 got=%0h exp=9", val2); end
  endtask

  task automatic test_x0();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0; issue_rob_id = 4'd4;
    commit_valid = 1'b1; commit_rd = 5'd0; commit_rob_id = 4'd4; commit_value = 32'h55;
    step();
    idle();
    rs1 = 5'd0;
    #1;
    checks++; if (val1 !== 32'h0) begin fails++; $display("FAIL x0_val1 got=%0h exp=0", val1); end
    checks++; if (dep1 !== 1'b0) begin fails++; $display("FAIL x0_dep1 got=%0h exp=0", dep1); end
    checks++; if (get_rob_id1 !== 4'd0) begin fails++; $display("FAIL x0_getid1 got=%0h exp=0", get_rob_id1); end
  endtask

  task automatic test_clear();
    idle();
    commit_valid = 1'b1; commit_rd = 5'd9; commit_rob_id = 4'd0; commit_value = 32'h99;
    step();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd8; issue_rob_id = 4'd5;
    step();
    issue_rd = 5'd9; issue_rob_id = 4'd6;
    step();
    idle();
    rs1 = 5'd8; rs2 = 5'd9;
    #1;
    checks++; if (dep1 !== 1'b1 || tag1 !== 4'd5) begin fails++; $display("FAIL clr_pre1 got=%0h/%0h exp=1/5", dep1, tag1); end
    checks++; if (dep2 !== 1'b1 || tag2 !== 4'd6) begin fails++; $display("FAIL clr_pre2 got=%0h/%0h exp=1/6", dep2, tag2); end
    clear = 1'b1;
    commit_valid = 1'b1; commit_rd = 5'd8; commit_rob_id = 4'd5; commit_value = 32'h10;
    issue_valid = 1'b1; issue_rd = 5'd10; issue_rob_id = 4'd7;
    step();
    idle();
    rs1 = 5'd8; rs2 = 5'd9;
    #1;
    checks++; if (val1 !== 32'h10 || dep1 !== 1'b0) begin fails++; $display("FAIL clr_x8 got=%0h/%0h exp=10/0", val1, dep1); end
    checks++; if (val2 !== 32'h99 || dep2 !== 1'b0) begin fails++; $display("FAIL clr_x9 got=%0h/%0h exp=99/0", val2, dep2); end
    rs1 = 5'd10;
    #1;
    checks++; if (dep1 !== 1'b0 || val1 !== 32'h0) begin fails++; $display("FAIL clr_issue_ignored got=%0h/%0h exp=0/0", dep1, val1); end
  endtask

  task automatic test_same_cycle();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd12; issue_rob_id = 4'd8;
    step();
    issue_rob_id = 4'd9;
    commit_valid = 1'b1; commit_rd = 5'd12; commit_rob_id = 4'd8; commit_value = 32'h1234;
    step();
    idle();
    rs1 = 5'd12;
    #1;
    checks++; if (dep1 !== 1'b1 || tag1 !== 4'd9) begin fails++; $display("FAIL same_issue_wins got=%0h/%0h exp=1/9", dep1, tag1); end
    commit_valid = 1'b1; commit_rd = 5'd12; commit_rob_id = 4'd9; commit_value = 32'h5678;
    #1;
    checks++; if (val1 !== 32'h5678 || dep1 !== 1'b0) begin fails++; $display("FAIL same_bypass got=%0h/%0h exp=5678/0", val1, dep1); end
    step();
    idle();
  endtask

  task automatic test_rd_eq_rs();
    idle();
    commit_valid = 1'b1; commit_rd = 5'd13; commit_value = 32'h13;
    step();
    idle();
    issue_valid = 1'b1; issue_rd = 5'd13; issue_rob_id = 4'd3;
    rs1 = 5'd13;
    #1;
    checks++; if (val1 !== 32'h13 || dep1 !== 1'b0) begin fails++; $display("FAIL rdrs_old got=%0h/%0h exp=13/0", val1, dep1); end
    step();
    idle();
    rs1 = 5'd13;
    #1;
    checks++; if (dep1 !== 1'b1 || tag1 !== 4'd3) begin fails++; $display("FAIL rdrs_new got=%0h/%0h exp=1/3", dep1, tag1); end
  endtask

  task automatic test_rdy_and_reset();
    idle();
    rdy = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3; issue_rob_id = 4'd2;
    commit_valid = 1'b1; commit_rd = 5'd4; commit_value = 32'hFF;
    step();
    idle();
    rs1 = 5'd3; rs2 = 5'd4;
    #1;
    checks++; if (dep1 !== 1'b0 || get_rob_id1 !== 4'd0) begin fails++; $display("FAIL hold_issue got=%0h/%0h exp=0/0", dep1, get_rob_id1); end
    checks++; if (val2 !== 32'h0) begin fails++; $display("FAIL hold_commit got=%0h exp=0", val2); end
    rst = 1'b0; rdy = 1'b0;
    step();
    idle();
    rs1 = 5'd13; rs2 = 5'd8;
    #1;
    checks++; if (val1 !== 32'h0 || dep1 !== 1'b0 || tag1 !== 4'd0 || get_rob_id1 !== 4'd0)
      begin fails++; $display("FAIL rst2_p1 got=%0h/%0h/%0h/%0h exp=0/0/0/0", val1, dep1, tag1, get_rob_id1); end
    checks++; if (val2 !== 32'h0 || dep2 !== 1'b0 || tag2 !== 4'd0 || get_rob_id2 !== 4'd0)
      begin fails++; $display("FAIL rst2_p2 got=%0h/%0h/%0h/%0h exp=0/0/0/0", val2, dep2, tag2, get_rob_id2); end
  endtask

  initial begin
    idle();
    #2;
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_x0();
    test_clear();
    test_same_cycle();
    test_rd_eq_rs();
    test_rdy_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
